// File: rtl/spdif_pkg.sv
// Shared constants and types for the S/PDIF (IEC 60958) transmitter.
// Defines the preamble patterns, the subframe slot map and the frame/block sizes.
package spdif_pkg;

  localparam int SLOTS_PER_SUBFRAME      = 32;
  localparam int HALF_CELLS_PER_SUBFRAME = 2 * SLOTS_PER_SUBFRAME;
  localparam int FRAMES_PER_BLOCK        = 192;

  // Preamble patterns in half-cell order, MSB first. A 1 means the level is
  // opposite to the line level just before the preamble.
  localparam logic [7:0] PREAMBLE_B = 8'b1110_1000;
  localparam logic [7:0] PREAMBLE_M = 8'b1110_0010;
  localparam logic [7:0] PREAMBLE_W = 8'b1110_0100;

  localparam logic [4:0] SLOT_AUDIO_FIRST = 5'd4;
  localparam logic [4:0] SLOT_AUDIO_LAST  = 5'd27;
  localparam logic [4:0] SLOT_V           = 5'd28;
  localparam logic [4:0] SLOT_U           = 5'd29;
  localparam logic [4:0] SLOT_C           = 5'd30;
  localparam logic [4:0] SLOT_P           = 5'd31;

  localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_BLOCK - 1);

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

  typedef enum logic [1:0] {
    PRE_B,
    PRE_M,
    PRE_W
  } preamble_e;

  function automatic logic [7:0] preamble_bits(input preamble_e p);
    case (p)
      PRE_B:   return PREAMBLE_B;
      PRE_M:   return PREAMBLE_M;
      default: return PREAMBLE_W;
    endcase
  endfunction

endpackage

// File: rtl/spdif_bmc_enc.sv
// Biphase-mark line encoder: owns the registered line level and the
// reference level captured at each preamble start.
module spdif_bmc_enc (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic first_half_i,
  input  logic bit_i,
  input  logic pre_i,
  input  logic pre_start_i,
  input  logic pre_bit_i,
  output logic signal_o
);

  logic signal_q, signal_d;
  logic ref_q, ref_d;

  always_comb begin
    signal_d = signal_q;
    ref_d    = ref_q;
    if (tick_i) begin
      if (pre_i) begin
        // Preamble levels are absolute relative to the level before it,
        // so the reference is grabbed from the live line at half-cell 0.
        if (pre_start_i) begin
          ref_d    = signal_q;
          signal_d = signal_q ^ pre_bit_i;
        end else begin
          signal_d = ref_q ^ pre_bit_i;
        end
      end else if (first_half_i) begin
        signal_d = ~signal_q;
      end else begin
        signal_d = signal_q ^ bit_i;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      signal_q <= 1'b0;
      ref_q    <= 1'b0;
    end else begin
      signal_q <= signal_d;
      ref_q    <= ref_d;
    end
  end

  assign signal_o = signal_q;

endmodule

// File: rtl/spdif_tx.sv
// S/PDIF transmitter top: half-cell timing, subframe/frame sequencing,
// sample handshake, parity and U/C bit selection feeding the BMC encoder.
module spdif_tx
  import spdif_pkg::*;
#(
  parameter int CLK_PER_BIT      = 8,
  parameter int CLK_PER_BIT_LOG2 = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [23:0]  data_i,
  input  logic         valid_i,
  output logic         ack_o,
  output logic         lrck_o,
  input  logic [191:0] udata_i,
  input  logic [191:0] cdata_i,
  output logic         underrun_o,
  output logic         signal_o
);

  localparam int HALF = CLK_PER_BIT / 2;
  localparam int CW   = (CLK_PER_BIT_LOG2 > 1) ? CLK_PER_BIT_LOG2 - 1 : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [5:0]     hc_q, hc_d;
  channel_e       ch_q, ch_d;
  logic [7:0]     frame_q, frame_d;
  logic [23:0]    data_q, data_d;
  logic           v_q, v_d;
  logic [191:0]   ublk_q, ublk_d;
  logic [191:0]   cblk_q, cblk_d;
  logic           parity_q, parity_d;

  logic           tick;
  logic           cell_end;
  logic           sub_start;
  logic           first_half;
  logic           is_pre;
  logic [4:0]     slot;
  logic [4:0]     audio_idx;
  logic [7:0]     blk_idx;
  logic           slot_bit;
  preamble_e      pre_sel;
  logic [7:0]     pre_pattern;
  logic           pre_bit;

  assign tick       = (cnt_q == '0);
  assign cell_end   = (cnt_q == HALF_LAST);
  assign sub_start  = tick && (hc_q == 6'd0);
  assign first_half = ~hc_q[0];
  assign is_pre     = (hc_q < 6'd8);
  assign slot       = hc_q[5:1];
  assign audio_idx  = slot - SLOT_AUDIO_FIRST;
  assign blk_idx    = FRAME_LAST - frame_q;

  // The request/consume strobes are combinational on the subframe-start
  // cycle; gating with rst keeps them low while reset is held.
  assign ack_o      = rst && sub_start && valid_i;
  assign underrun_o = rst && sub_start && !valid_i;
  assign lrck_o     = ch_q;

  always_comb begin
    pre_sel = PRE_W;
    if (ch_q == CH_LEFT) begin
      pre_sel = (frame_q == 8'd0) ? PRE_B : PRE_M;
    end
  end

  assign pre_pattern = preamble_bits(pre_sel);
  assign pre_bit     = pre_pattern[3'd7 - hc_q[2:0]];

  always_comb begin
    slot_bit = 1'b0;
    if (slot >= SLOT_AUDIO_FIRST && slot <= SLOT_AUDIO_LAST) begin
      slot_bit = data_q[audio_idx];
    end else begin
      case (slot)
        SLOT_V:  slot_bit = v_q;
        SLOT_U:  slot_bit = ublk_q[blk_idx];
        SLOT_C:  slot_bit = cblk_q[blk_idx];
        SLOT_P:  slot_bit = parity_q;
        default: slot_bit = 1'b0;
      endcase
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path
  // through this block leaves a variable unassigned (no latches).
  always_comb begin
    cnt_d    = cell_end ? '0 : cnt_q + 1'b1;
    hc_d     = hc_q;
    ch_d     = ch_q;
    frame_d  = frame_q;
    data_d   = data_q;
    v_d      = v_q;
    ublk_d   = ublk_q;
    cblk_d   = cblk_q;
    parity_d = parity_q;

    if (cell_end) begin
      hc_d = hc_q + 6'd1;
      if (hc_q == 6'(HALF_CELLS_PER_SUBFRAME - 1)) begin
        ch_d = (ch_q == CH_LEFT) ? CH_RIGHT : CH_LEFT;
        if (ch_q == CH_RIGHT) begin
          frame_d = (frame_q == FRAME_LAST) ? 8'd0 : frame_q + 8'd1;
        end
      end
    end

    if (sub_start) begin
      data_d = valid_i ? data_i : 24'd0;
      v_d    = ~valid_i;
      if (ch_q == CH_LEFT && frame_q == 8'd0) begin
        ublk_d = udata_i;
        cblk_d = cdata_i;
      end
    end

    // Parity covers slots 4..30 and is emitted in slot 31.
    if (tick && first_half && !is_pre && slot != SLOT_P) begin
      parity_d = (slot == SLOT_AUDIO_FIRST) ? slot_bit : (parity_q ^ slot_bit);
    end
  end

  // NOTE: the 192-bit block registers are reset along with everything else,
  // so U/C never carry unknowns even if read before the first block latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      hc_q     <= 6'd0;
      ch_q     <= CH_LEFT;
      frame_q  <= 8'd0;
      data_q   <= 24'd0;
      v_q      <= 1'b0;
      ublk_q   <= '0;
      cblk_q   <= '0;
      parity_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hc_q     <= hc_d;
      ch_q     <= ch_d;
      frame_q  <= frame_d;
      data_q   <= data_d;
      v_q      <= v_d;
      ublk_q   <= ublk_d;
      cblk_q   <= cblk_d;
      parity_q <= parity_d;
    end
  end

  spdif_bmc_enc u_bmc_enc (
    .clk          (clk),
    .rst          (rst),
    .tick_i       (tick),
    .first_half_i (first_half),
    .bit_i        (slot_bit),
    .pre_i        (is_pre),
    .pre_start_i  (hc_q == 6'd0),
    .pre_bit_i    (pre_bit),
    .signal_o     (signal_o)
  );

endmodule
